layer_controller_neuron_mac: RTL and testbench

LAYER_CONTROLLER_NEURON_MAC -- requirements
Module: layer_controller_neuron_mac

---
 rtl/layer_controller_pkg.sv | 19 +
 rtl/layer_controller_neuron_act.sv | 34 +++
 rtl/layer_controller_neuron_mac.sv | 118 +++++++++++
 tb/tb_layer_controller_neuron_mac.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_controller_pkg.sv
// Shared defaults and FSM state encoding for the neuron MAC layer controller.
package layer_controller_pkg;

    localparam int LC_DATA_W    = 9;
    localparam int LC_ACC_W     = 24;
    localparam int LC_FRAC_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ACT   = 2'd2,
        OUT   = 2'd3
    } lc_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/layer_controller_neuron_act.sv
// Combinational output stage: floor shift of the accumulator, clamp to DATA_W, activation.
// Activation is ReLU when LAYER_CONTROLLER_NEURON_RELU_EN is defined, identity otherwise.
module layer_controller_neuron_act
    import layer_controller_pkg::*;
#(
    parameter int DATA_W    = LC_DATA_W,
    parameter int ACC_W     = LC_ACC_W,
    parameter int FRAC_BITS = LC_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] result,
    output logic                     clip
);

    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] clamped;

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        clip    = (shifted[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){shifted[ACC_W-1]}});
        if (clip) begin
            clamped = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            clamped = shifted[DATA_W-1:0];
        end
`ifdef LAYER_CONTROLLER_NEURON_RELU_EN
        result = clamped[DATA_W-1] ? '0 : clamped;
`else
        result = clamped;
`endif
    end

endmodule

// File: rtl/layer_controller_neuron_mac.sv
// Single-neuron MAC: accumulates in_data*weight beats on top of a bias, then emits one
// activated result per vector. Activation selected by LAYER_CONTROLLER_NEURON_RELU_EN.
//
// state | meaning
// IDLE  | waiting for the first beat of a vector; previous outputs retained
// ACCUM | vector in progress, accumulating beats
// ACT   | one cycle: shift/clamp/activate acc into result
// OUT   | result presented until out_ready
module layer_controller_neuron_mac
    import layer_controller_pkg::*;
#(
    parameter int DATA_W    = LC_DATA_W,
    parameter int ACC_W     = LC_ACC_W,
    parameter int FRAC_BITS = LC_FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat,
    output logic [7:0]               beat_cnt
);

    localparam int PROD_W = 2 * DATA_W;
    // One guard bit over the widest operand catches any overflow of the ACC_W sum.
    localparam int SUM_W  = max_int(ACC_W, max_int(PROD_W, DATA_W + FRAC_BITS)) + 1;

    lc_state_e                state, state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] product;
    logic signed [SUM_W-1:0]  base_ext;
    logic signed [SUM_W-1:0]  sum_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     acc_clip;
    logic                     beat_acc;
    logic signed [DATA_W-1:0] act_result;
    logic                     act_clip;

    always_comb begin
        product  = PROD_W'(in_data) * PROD_W'(weight);
        base_ext = (state == IDLE) ? (SUM_W'(bias) <<< FRAC_BITS) : SUM_W'(acc);
        sum_ext  = base_ext + SUM_W'(product);
        acc_clip = (sum_ext[SUM_W-1:ACC_W-1] != {(SUM_W-ACC_W+1){sum_ext[SUM_W-1]}});
        if (acc_clip) begin
            acc_sum = sum_ext[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_sum = sum_ext[ACC_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_last ? ACT : ACCUM;
            end
            ACT:     state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign beat_acc = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            result   <= '0;
            sat      <= 1'b0;
            beat_cnt <= 8'd0;
        end else begin
            if (beat_acc) begin
                acc <= acc_sum;
                if (state == IDLE) begin
                    beat_cnt <= 8'd1;
                    sat      <= acc_clip;
                end else begin
                    if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                    sat <= sat | acc_clip;
                end
            end
            if (state == ACT) begin
                result <= act_result;
                sat    <= sat | act_clip;
            end
        end
    end

    layer_controller_neuron_act #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_act (
        .acc    (acc),
        .result (act_result),
        .clip   (act_clip)
    );

endmodule

// File: tb/tb_layer_controller_neuron_mac.sv
// Scoreboard bench for layer_controller_neuron_mac: stimulus pushes expected results,
// a negedge monitor pops and compares on each output handshake.
module tb_layer_controller_neuron_mac;

    logic              clk;
    logic              reset;
    logic signed [8:0] in_data;
    logic signed [8:0] weight;
    logic signed [8:0] bias;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic signed [8:0] result;
    logic              out_valid;
    logic              out_ready;
    logic              sat;
    logic [7:0]        beat_cnt;

    typedef struct {
        logic signed [8:0] res;
        logic              sat;
        logic [7:0]        cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

`ifdef LAYER_CONTROLLER_NEURON_RELU_EN
    localparam int EXP_NEG = 0;
`else
    localparam int EXP_NEG = -16;
`endif

    layer_controller_neuron_mac dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .weight    (weight),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push_exp(input int r, input logic s, input int c);
        exp_t e;
        e.res = 9'(r);
        e.sat = s;
        e.cnt = 8'(c);
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input logic signed [8:0] d, input logic signed [8:0] w,
                             input logic last);
        int n;
        in_data  = d;
        weight   = w;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) begin
            check("act_out_valid", out_valid, 0);
            check("act_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            check("latency_out_valid", out_valid, 1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got result %0d expected no output",
                             result);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("mon_result", result, mon_e.res);
                    check("mon_sat", sat, mon_e.sat);
                    check("mon_beat_cnt", beat_cnt, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        weight    = '0;
        bias      = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_sat", sat, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        reset = 1'b0;

        // single beat 1.0 * 2.0
        bias = 0;
        push_exp(32, 1'b0, 1);
        send_beat(9'sd16, 9'sd32, 1'b1);
        wait_drain();

        // 1.0*2.0 + 1.0*-3.0 = -1.0
        push_exp(EXP_NEG, 1'b0, 2);
        send_beat(9'sd16, 9'sd32, 1'b0);
        send_beat(9'sd16, -9'sd48, 1'b1);
        wait_drain();

        // large products clip the DATA_W result
        push_exp(255, 1'b1, 4);
        for (int i = 0; i < 4; i++) send_beat(9'sd255, 9'sd255, (i == 3));
        wait_drain();

        // backpressure in OUT; 2.0*1.0 + bias 1/16 -> 33
        out_ready = 1'b0;
        bias = 1;
        push_exp(33, 1'b0, 1);
        send_beat(9'sd32, 9'sd16, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 9'sd5;
            weight   = 9'sd7;
            in_last  = 1'b1;
            check("hold_result", result, 33);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_beat_cnt", beat_cnt, 1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("idle_result_kept", result, 33);
        check("drain_after_hold", exp_q.size(), 0);

        // reset mid-vector discards the partial vector
        bias = 0;
        send_beat(9'sd16, 9'sd16, 1'b0);
        send_beat(9'sd16, 9'sd16, 1'b0);
        in_data  = 9'sd16;
        weight   = 9'sd16;
        in_last  = 1'b1;
        in_valid = 1'b1;
        reset    = 1'b1;
        #1;
        check("midrst_result", result, 0);
        check("midrst_sat", sat, 0);
        check("midrst_beat_cnt", beat_cnt, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_output", out_valid, 0);
        bias = 16;
        push_exp(32, 1'b0, 1);
        send_beat(9'sd16, 9'sd16, 1'b1);
        wait_drain();

        // reset while a result is pending in OUT
        out_ready = 1'b0;
        bias = 0;
        send_beat(9'sd16, 9'sd16, 1'b1);
        reset = 1'b1;
        #1;
        check("outrst_out_valid", out_valid, 0);
        check("outrst_result", result, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("outrst_no_output", out_valid, 0);

        // beat counter holds at 255
        push_exp(0, 1'b0, 255);
        for (int i = 1; i <= 260; i++) send_beat(9'sd0, 9'sd0, (i == 260));
        wait_drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
